// File: rtl/idu_stage.sv
// idu_stage: instruction-decode stage of the multi-cycle RV64 core.
// Latches one fetch packet per IFU handshake, decodes it against the integer
// register file owned by this stage, and presents a registered decode packet
// to the execute stage until it is accepted.
// Optional feature macro: IDU_RVM_EN (decode of the M extension to the MDU).
module idu_stage #(
    parameter int XLEN = 64
) (
    input  logic            clock,
    input  logic            reset,
    // fetch side
    input  logic            ioIFU_valid,
    output logic            ioIFU_ready,
    input  logic [31:0]     ioIFU_inst,
    input  logic [XLEN-1:0] ioIFU_pc,
    input  logic [XLEN-1:0] ioIFU_pc4,
    // writeback port into the register file
    input  logic            ioRf_wen,
    input  logic [4:0]      ioRf_waddr,
    input  logic [XLEN-1:0] ioRf_wdata,
    // execute side
    output logic            ioEXU_valid,
    input  logic            ioEXU_ready,
    output logic [XLEN-1:0] ioEXU_pc,
    output logic [XLEN-1:0] ioEXU_pc4,
    output logic [XLEN-1:0] ioEXU_src1,
    output logic [XLEN-1:0] ioEXU_src2,
    output logic [XLEN-1:0] ioEXU_imm,
    output logic [4:0]      ioEXU_rd,
    output logic            ioEXU_rdWen,
    output logic [2:0]      ioEXU_fuType,
    output logic [4:0]      ioEXU_fuOp,
    output logic            ioEXU_illegal
);

    // Major opcodes (bits [1:0] = 2'b11 are part of every legal opcode, so
    // a compressed-quadrant word never matches and falls to the illegal path).
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_OP32     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [2:0] FU_ALU = 3'd0;
    localparam logic [2:0] FU_BRU = 3'd1;
    localparam logic [2:0] FU_LSU = 3'd2;
    localparam logic [2:0] FU_MDU = 3'd3;
    localparam logic [2:0] FU_SYS = 3'd4;
    localparam logic [2:0] FU_ILL = 3'd7;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic [2:0] {
        IDLE = 3'b001,
        READ = 3'b010,
        HOLD = 3'b100
    } state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
        logic [XLEN-1:0] src1;
        logic [XLEN-1:0] src2;
        logic [XLEN-1:0] imm;
        logic [4:0]      rd;
        logic            rd_wen;
        logic [2:0]      fu_type;
        logic [4:0]      fu_op;
        logic            illegal;
    } pkt_t;

    // Immediate extraction helpers; every format sign-extends from inst[31].
    function automatic logic [XLEN-1:0] imm_i(input logic [31:0] inst);
        return {{(XLEN-12){inst[31]}}, inst[31:20]};
    endfunction

    function automatic logic [XLEN-1:0] imm_s(input logic [31:0] inst);
        return {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
    endfunction

    function automatic logic [XLEN-1:0] imm_b(input logic [31:0] inst);
        return {{(XLEN-13){inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

    function automatic logic [XLEN-1:0] imm_u(input logic [31:0] inst);
        return {{(XLEN-32){inst[31]}}, inst[31:12], 12'h000};
    endfunction

    function automatic logic [XLEN-1:0] imm_j(input logic [31:0] inst);
        return {{(XLEN-21){inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

    state_t          state_q, state_d;
    logic [31:0]     inst_q, inst_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pc4_q, pc4_d;
    logic            ifu_ready_q, ifu_ready_d;
    logic            exu_valid_q, exu_valid_d;
    pkt_t            pkt_q, pkt_d;
    logic [XLEN-1:0] rf_q [32];

    logic [6:0]      opcode_s;
    logic [2:0]      funct3_s;
    logic [6:0]      funct7_s;
    logic [4:0]      rs1_s;
    logic [4:0]      rs2_s;
    logic [4:0]      rd_s;
    logic [XLEN-1:0] src1_s;
    logic [XLEN-1:0] src2_s;
    logic [XLEN-1:0] dec_imm_s;
    logic [2:0]      dec_fu_type_s;
    logic            dec_illegal_s;
    logic            dec_word_s;
    logic            dec_wb_s;
    logic            dec_mdu_s;
    logic [4:0]      dec_fu_op_s;
    logic            dec_rd_wen_s;

    assign opcode_s = inst_q[6:0];
    assign funct3_s = inst_q[14:12];
    assign funct7_s = inst_q[31:25];
    assign rs1_s    = inst_q[19:15];
    assign rs2_s    = inst_q[24:20];
    assign rd_s     = inst_q[11:7];

    // Operand read with write-through of a same-cycle writeback; x0 is
    // never written, so its storage stays zero and needs no special read path.
    always_comb begin
        src1_s = rf_q[rs1_s];
        src2_s = rf_q[rs2_s];
        if (ioRf_wen && (ioRf_waddr == rs1_s) && (rs1_s != 5'd0)) begin
            src1_s = ioRf_wdata;
        end else begin
            src1_s = rf_q[rs1_s];
        end
        if (ioRf_wen && (ioRf_waddr == rs2_s) && (rs2_s != 5'd0)) begin
            src2_s = ioRf_wdata;
        end else begin
            src2_s = rf_q[rs2_s];
        end
    end

    // Decode of the latched instruction into unit, immediate and write flag.
    always_comb begin
        dec_imm_s     = {XLEN{1'b0}};
        dec_fu_type_s = FU_ILL;
        dec_illegal_s = 1'b1;
        dec_word_s    = 1'b0;
        dec_wb_s      = 1'b0;
        dec_mdu_s     = 1'b0;
        case (opcode_s)
            OPC_OP_IMM, OPC_OP_IMM32: begin
                dec_imm_s     = imm_i(inst_q);
                dec_fu_type_s = FU_ALU;
                dec_illegal_s = 1'b0;
                dec_word_s    = (opcode_s == OPC_OP_IMM32);
                dec_wb_s      = 1'b1;
            end
            OPC_OP, OPC_OP32: begin
                dec_word_s = (opcode_s == OPC_OP32);
                if (funct7_s == FUNCT7_MULDIV) begin
`ifdef IDU_RVM_EN
                    dec_fu_type_s = FU_MDU;
                    dec_illegal_s = 1'b0;
                    dec_wb_s      = 1'b1;
                    dec_mdu_s     = 1'b1;
`else
                    dec_fu_type_s = FU_ILL;
                    dec_illegal_s = 1'b1;
                    dec_wb_s      = 1'b0;
                    dec_mdu_s     = 1'b0;
`endif
                end else begin
                    dec_fu_type_s = FU_ALU;
                    dec_illegal_s = 1'b0;
                    dec_wb_s      = 1'b1;
                end
            end
            OPC_LUI, OPC_AUIPC: begin
                dec_imm_s     = imm_u(inst_q);
                dec_fu_type_s = FU_ALU;
                dec_illegal_s = 1'b0;
                dec_wb_s      = 1'b1;
            end
            OPC_JAL: begin
                dec_imm_s     = imm_j(inst_q);
                dec_fu_type_s = FU_BRU;
                dec_illegal_s = 1'b0;
                dec_wb_s      = 1'b1;
            end
            OPC_JALR: begin
                dec_imm_s     = imm_i(inst_q);
                dec_fu_type_s = FU_BRU;
                dec_illegal_s = 1'b0;
                dec_wb_s      = 1'b1;
            end
            OPC_BRANCH: begin
                dec_imm_s     = imm_b(inst_q);
                dec_fu_type_s = FU_BRU;
                dec_illegal_s = 1'b0;
            end
            OPC_LOAD: begin
                dec_imm_s     = imm_i(inst_q);
                dec_fu_type_s = FU_LSU;
                dec_illegal_s = 1'b0;
                dec_word_s    = ~funct3_s[2];
                dec_wb_s      = 1'b1;
            end
            OPC_STORE: begin
                dec_imm_s     = imm_s(inst_q);
                dec_fu_type_s = FU_LSU;
                dec_illegal_s = 1'b0;
                dec_word_s    = ~funct3_s[2];
            end
            OPC_SYSTEM: begin
                // Only ECALL and EBREAK are supported; CSR access is illegal.
                if ((inst_q[31:7] == 25'h0000000) || (inst_q[31:7] == 25'h0002000)) begin
                    dec_imm_s     = imm_i(inst_q);
                    dec_fu_type_s = FU_SYS;
                    dec_illegal_s = 1'b0;
                end else begin
                    dec_fu_type_s = FU_ILL;
                    dec_illegal_s = 1'b1;
                end
            end
            default: begin
                dec_fu_type_s = FU_ILL;
                dec_illegal_s = 1'b1;
            end
        endcase
    end

    // Operation code and final destination-write flag.
    always_comb begin
        dec_fu_op_s  = 5'd0;
        dec_rd_wen_s = dec_wb_s && (rd_s != 5'd0);
        if (dec_illegal_s) begin
            dec_fu_op_s = 5'd0;
        end else if (dec_mdu_s) begin
            dec_fu_op_s = {1'b0, funct3_s, dec_word_s};
        end else begin
            dec_fu_op_s = {inst_q[30], funct3_s, dec_word_s};
        end
    end

    // Handshake FSM: next state plus capture of the fetch packet in IDLE.
    always_comb begin
        state_d = state_q;
        inst_d  = inst_q;
        pc_d    = pc_q;
        pc4_d   = pc4_q;
        case (state_q)
            IDLE: begin
                if (ioIFU_valid) begin
                    state_d = READ;
                    inst_d  = ioIFU_inst;
                    pc_d    = ioIFU_pc;
                    pc4_d   = ioIFU_pc4;
                end else begin
                    state_d = IDLE;
                end
            end
            READ: begin
                state_d = HOLD;
            end
            HOLD: begin
                if (ioEXU_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        ifu_ready_d = (state_d == IDLE);
        exu_valid_d = (state_d == HOLD);
    end

    // Decode packet: loaded in READ, frozen in every other state.
    always_comb begin
        pkt_d = pkt_q;
        if (state_q == READ) begin
            pkt_d.pc      = pc_q;
            pkt_d.pc4     = pc4_q;
            pkt_d.src1    = src1_s;
            pkt_d.src2    = src2_s;
            pkt_d.imm     = dec_imm_s;
            pkt_d.rd      = rd_s;
            pkt_d.rd_wen  = dec_rd_wen_s;
            pkt_d.fu_type = dec_fu_type_s;
            pkt_d.fu_op   = dec_fu_op_s;
            pkt_d.illegal = dec_illegal_s;
        end else begin
            pkt_d = pkt_q;
        end
    end

    // Control, latched fetch packet and output packet registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            inst_q      <= 32'h0000_0000;
            pc_q        <= {XLEN{1'b0}};
            pc4_q       <= {XLEN{1'b0}};
            ifu_ready_q <= 1'b1;
            exu_valid_q <= 1'b0;
            pkt_q       <= '0;
        end else begin
            state_q     <= state_d;
            inst_q      <= inst_d;
            pc_q        <= pc_d;
            pc4_q       <= pc4_d;
            ifu_ready_q <= ifu_ready_d;
            exu_valid_q <= exu_valid_d;
            pkt_q       <= pkt_d;
        end
    end

    // Integer register file; writeback accepted in every state, x0 ignored.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= {XLEN{1'b0}};
            end
        end else if (ioRf_wen && (ioRf_waddr != 5'd0)) begin
            rf_q[ioRf_waddr] <= ioRf_wdata;
        end
    end

    assign ioIFU_ready   = ifu_ready_q;
    assign ioEXU_valid   = exu_valid_q;
    assign ioEXU_pc      = pkt_q.pc;
    assign ioEXU_pc4     = pkt_q.pc4;
    assign ioEXU_src1    = pkt_q.src1;
    assign ioEXU_src2    = pkt_q.src2;
    assign ioEXU_imm     = pkt_q.imm;
    assign ioEXU_rd      = pkt_q.rd;
    assign ioEXU_rdWen   = pkt_q.rd_wen;
    assign ioEXU_fuType  = pkt_q.fu_type;
    assign ioEXU_fuOp    = pkt_q.fu_op;
    assign ioEXU_illegal = pkt_q.illegal;

endmodule

// File: tb/tb_idu_stage.sv
// Directed testbench for idu_stage: hand-computed decode packets, register
// file forwarding, backpressure and reset behaviour.
module tb_idu_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        ioIFU_valid;
    logic        ioIFU_ready;
    logic [31:0] ioIFU_inst;
    logic [63:0] ioIFU_pc;
    logic [63:0] ioIFU_pc4;
    logic        ioRf_wen;
    logic [4:0]  ioRf_waddr;
    logic [63:0] ioRf_wdata;
    logic        ioEXU_valid;
    logic        ioEXU_ready;
    logic [63:0] ioEXU_pc;
    logic [63:0] ioEXU_pc4;
    logic [63:0] ioEXU_src1;
    logic [63:0] ioEXU_src2;
    logic [63:0] ioEXU_imm;
    logic [4:0]  ioEXU_rd;
    logic        ioEXU_rdWen;
    logic [2:0]  ioEXU_fuType;
    logic [4:0]  ioEXU_fuOp;
    logic        ioEXU_illegal;

    int n_checks = 0;
    int n_pass   = 0;

    idu_stage #(.XLEN(64)) dut (
        .clock        (clock),
        .reset        (reset),
        .ioIFU_valid  (ioIFU_valid),
        .ioIFU_ready  (ioIFU_ready),
        .ioIFU_inst   (ioIFU_inst),
        .ioIFU_pc     (ioIFU_pc),
        .ioIFU_pc4    (ioIFU_pc4),
        .ioRf_wen     (ioRf_wen),
        .ioRf_waddr   (ioRf_waddr),
        .ioRf_wdata   (ioRf_wdata),
        .ioEXU_valid  (ioEXU_valid),
        .ioEXU_ready  (ioEXU_ready),
        .ioEXU_pc     (ioEXU_pc),
        .ioEXU_pc4    (ioEXU_pc4),
        .ioEXU_src1   (ioEXU_src1),
        .ioEXU_src2   (ioEXU_src2),
        .ioEXU_imm    (ioEXU_imm),
        .ioEXU_rd     (ioEXU_rd),
        .ioEXU_rdWen  (ioEXU_rdWen),
        .ioEXU_fuType (ioEXU_fuType),
        .ioEXU_fuOp   (ioEXU_fuOp),
        .ioEXU_illegal(ioEXU_illegal)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Present one fetch packet for a single cycle, then scramble the inputs.
    task automatic accept(input logic [31:0] inst, input logic [63:0] pc);
        ioIFU_valid = 1'b1;
        ioIFU_inst  = inst;
        ioIFU_pc    = pc;
        ioIFU_pc4   = pc + 64'd4;
        tick();
        ioIFU_valid = 1'b0;
        ioIFU_inst  = 32'hFFFF_FFFF;
        ioIFU_pc    = 64'hDEAD_BEEF_DEAD_BEEF;
        ioIFU_pc4   = 64'hDEAD_BEEF_DEAD_BEEF;
    endtask

    task automatic release_pkt;
        ioEXU_ready = 1'b1;
        tick();
        ioEXU_ready = 1'b0;
    endtask

    task automatic write_reg(input logic [4:0] addr, input logic [63:0] data);
        ioRf_wen   = 1'b1;
        ioRf_waddr = addr;
        ioRf_wdata = data;
        tick();
        ioRf_wen   = 1'b0;
    endtask

    // Full transaction without writeback activity; checker sees the packet.
    task automatic issue(input logic [31:0] inst, input logic [63:0] pc);
        accept(inst, pc);
        tick();
    endtask

    logic [2:0] mul_fu;
    logic       mul_ill;
    logic       mul_wen;

    initial begin
        reset       = 1'b1;
        ioIFU_valid = 1'b0;
        ioIFU_inst  = 32'h0;
        ioIFU_pc    = 64'h0;
        ioIFU_pc4   = 64'h0;
        ioRf_wen    = 1'b0;
        ioRf_waddr  = 5'd0;
        ioRf_wdata  = 64'h0;
        ioEXU_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // reset state
        chk("rst_ifu_ready", {63'd0, ioIFU_ready}, 64'd1);
        chk("rst_exu_valid", {63'd0, ioEXU_valid}, 64'd0);
        chk("rst_src1", ioEXU_src1, 64'd0);
        chk("rst_imm", ioEXU_imm, 64'd0);
        chk("rst_fuType", {61'd0, ioEXU_fuType}, 64'd0);
        chk("rst_rdWen", {63'd0, ioEXU_rdWen}, 64'd0);

        // addi x1,x0,5 : latency and basic decode
        accept(32'h0050_0093, 64'h0000_0000_8000_0000);
        chk("addi_read_valid", {63'd0, ioEXU_valid}, 64'd0);
        chk("addi_read_ready", {63'd0, ioIFU_ready}, 64'd0);
        tick();
        chk("addi_valid", {63'd0, ioEXU_valid}, 64'd1);
        chk("addi_fuType", {61'd0, ioEXU_fuType}, 64'd0);
        chk("addi_imm", ioEXU_imm, 64'd5);
        chk("addi_src1", ioEXU_src1, 64'd0);
        chk("addi_rd", {59'd0, ioEXU_rd}, 64'd1);
        chk("addi_rdWen", {63'd0, ioEXU_rdWen}, 64'd1);
        chk("addi_illegal", {63'd0, ioEXU_illegal}, 64'd0);
        chk("addi_fuOp", {59'd0, ioEXU_fuOp}, 64'd0);
        chk("addi_pc", ioEXU_pc, 64'h0000_0000_8000_0000);
        chk("addi_pc4", ioEXU_pc4, 64'h0000_0000_8000_0004);
        release_pkt();
        chk("addi_rel_valid", {63'd0, ioEXU_valid}, 64'd0);
        chk("addi_rel_ready", {63'd0, ioIFU_ready}, 64'd1);

        // add x3,x2,x2 with writeback of x2 during READ
        accept(32'h0021_01b3, 64'h100);
        ioRf_wen   = 1'b1;
        ioRf_waddr = 5'd2;
        ioRf_wdata = 64'h1234;
        tick();
        ioRf_wen = 1'b0;
        chk("fwd_src1", ioEXU_src1, 64'h1234);
        chk("fwd_src2", ioEXU_src2, 64'h1234);
        chk("fwd_rd", {59'd0, ioEXU_rd}, 64'd3);
        release_pkt();
        issue(32'h0021_01b3, 64'h104);
        chk("x2_stored", ioEXU_src1, 64'h1234);
        release_pkt();

        // x0 writes ignored, both in IDLE and as a forwarding candidate
        write_reg(5'd0, 64'hDEAD);
        accept(32'h0000_0233, 64'h108);
        ioRf_wen   = 1'b1;
        ioRf_waddr = 5'd0;
        ioRf_wdata = 64'hBEEF;
        tick();
        ioRf_wen = 1'b0;
        chk("x0_src1", ioEXU_src1, 64'd0);
        chk("x0_src2", ioEXU_src2, 64'd0);
        chk("x0_rdWen", {63'd0, ioEXU_rdWen}, 64'd1);
        release_pkt();

        // sd x1,0(x0)
        write_reg(5'd1, 64'hABCD);
        issue(32'h0010_3023, 64'h10C);
        chk("sd_fuType", {61'd0, ioEXU_fuType}, 64'd2);
        chk("sd_rdWen", {63'd0, ioEXU_rdWen}, 64'd0);
        chk("sd_src2", ioEXU_src2, 64'hABCD);
        chk("sd_fuOp", {59'd0, ioEXU_fuOp}, 64'd7);
        release_pkt();

        // ld x5,-8(x1) held under backpressure for 5 cycles
        issue(32'hFF80_B283, 64'h110);
        for (int c = 0; c < 5; c++) begin
            chk("bp_valid", {63'd0, ioEXU_valid}, 64'd1);
            chk("bp_ifu_ready", {63'd0, ioIFU_ready}, 64'd0);
            chk("bp_src1", ioEXU_src1, 64'hABCD);
            chk("bp_imm", ioEXU_imm, 64'hFFFF_FFFF_FFFF_FFF8);
            chk("bp_fuOp", {59'd0, ioEXU_fuOp}, 64'd23);
            ioIFU_valid = 1'b1;
            ioIFU_inst  = 32'h0000_0233;
            ioRf_wen    = 1'b1;
            ioRf_waddr  = 5'd1;
            ioRf_wdata  = 64'h7777;
            tick();
        end
        ioIFU_valid = 1'b0;
        ioRf_wen    = 1'b0;
        chk("bp_src1_after", ioEXU_src1, 64'hABCD);
        release_pkt();
        chk("bp_rel_valid", {63'd0, ioEXU_valid}, 64'd0);
        chk("bp_rel_ready", {63'd0, ioIFU_ready}, 64'd1);
        tick();
        chk("bp_no_ghost", {63'd0, ioEXU_valid}, 64'd0);

        // add x6,x1,x0 : x1 written while in HOLD
        issue(32'h0000_8333, 64'h114);
        chk("hold_write_x1", ioEXU_src1, 64'h7777);
        release_pkt();

        // illegal encodings
        issue(32'hFFFF_FFFF, 64'h118);
        chk("ill_flag", {63'd0, ioEXU_illegal}, 64'd1);
        chk("ill_fuType", {61'd0, ioEXU_fuType}, 64'd7);
        chk("ill_rdWen", {63'd0, ioEXU_rdWen}, 64'd0);
        chk("ill_valid", {63'd0, ioEXU_valid}, 64'd1);
        release_pkt();
        issue(32'h0050_0091, 64'h11C);
        chk("quad_ill", {63'd0, ioEXU_illegal}, 64'd1);
        chk("quad_fuType", {61'd0, ioEXU_fuType}, 64'd7);
        release_pkt();

        // beq x0,x0,-4
        issue(32'hFE00_0EE3, 64'h120);
        chk("beq_fuType", {61'd0, ioEXU_fuType}, 64'd1);
        chk("beq_imm", ioEXU_imm, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("beq_rdWen", {63'd0, ioEXU_rdWen}, 64'd0);
        release_pkt();

        // lui x7,0x80000
        issue(32'h8000_03B7, 64'h124);
        chk("lui_imm", ioEXU_imm, 64'hFFFF_FFFF_8000_0000);
        chk("lui_fuType", {61'd0, ioEXU_fuType}, 64'd0);
        release_pkt();

        // mul x5,x6,x7
`ifdef IDU_RVM_EN
        mul_fu  = 3'd3;
        mul_ill = 1'b0;
        mul_wen = 1'b1;
`else
        mul_fu  = 3'd7;
        mul_ill = 1'b1;
        mul_wen = 1'b0;
`endif
        issue(32'h0273_02b3, 64'h128);
        chk("mul_fuType", {61'd0, ioEXU_fuType}, {61'd0, mul_fu});
        chk("mul_illegal", {63'd0, ioEXU_illegal}, {63'd0, mul_ill});
        chk("mul_rdWen", {63'd0, ioEXU_rdWen}, {63'd0, mul_wen});
        release_pkt();

        // reset while in READ discards the packet and clears the register file
        accept(32'h0050_0093, 64'h12C);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rstr_valid", {63'd0, ioEXU_valid}, 64'd0);
        chk("rstr_ready", {63'd0, ioIFU_ready}, 64'd1);
        chk("rstr_fuType", {61'd0, ioEXU_fuType}, 64'd0);
        chk("rstr_pc", ioEXU_pc, 64'd0);
        tick();
        chk("rstr_still_idle", {63'd0, ioEXU_valid}, 64'd0);
        issue(32'h0021_01b3, 64'h130);
        chk("rstr_rf_cleared", ioEXU_src1, 64'd0);
        release_pkt();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/idu_stage.md
# idu_stage

Instruction-decode stage of the multi-cycle RV64 core, directly downstream of the fetch unit and upstream of the execute unit. Accepts one fetched instruction per valid/ready handshake and decodes it into functional-unit type, operation, immediate and destination. Reads operands from the integer register file it owns. Hands a complete decode packet to the execute stage under a second valid/ready handshake; the register-file write port is driven by writeback.

## Interface
- XLEN, 64, datapath and register width
- RESET_PC_UNUSED: none; the block has no parameters other than XLEN
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- ioIFU_valid  in  1  fetch packet valid
- ioIFU_ready  out  1  stage can accept a packet
- ioIFU_inst  in  32  instruction word
- ioIFU_pc / ioIFU_pc4  in  64  instruction PC / PC+4
- ioRf_wen  in  1  writeback register write enable
- ioRf_waddr  in  5  writeback destination
- ioRf_wdata  in  64  writeback data
- ioEXU_valid  out  1  decode packet valid
- ioEXU_ready  in  1  execute stage accepts packet
- ioEXU_pc / ioEXU_pc4  out  64  forwarded PC / PC+4
- ioEXU_src1 / ioEXU_src2  out  64  rs1 / rs2 values
- ioEXU_imm  out  64  sign-extended immediate
- ioEXU_rd  out  5  destination register
- ioEXU_rdWen  out  1  destination write required (0 when rd = 0)
- ioEXU_fuType  out  3  0 ALU, 1 BRU, 2 LSU, 3 MDU, 4 SYS, 7 illegal
- ioEXU_fuOp  out  5  {inst[30], funct3, word}; word = 1 for OP-32/OP-IMM-32, and for loads/stores is the inverse of funct3[2] (0 for LBU/LHU/LWU)
- ioEXU_illegal  out  1  unsupported encoding

## Operation
- States: IDLE, READ, HOLD (one-hot).
- IDLE: ioIFU_ready = 1. On ioIFU_valid, latch inst/pc/pc4 and go to READ; ioIFU_ready drops the next cycle.
- READ: decode the latched instruction, read rs1/rs2 and register all outputs. Assert ioEXU_valid at the end of the cycle. Go to HOLD.
- HOLD: ioEXU_valid = 1 and all ioEXU_* outputs held stable. On ioEXU_ready, drop valid, raise ioIFU_ready and go to IDLE.
- Register file: 32 x XLEN, cleared to 0 on reset, written on posedge when ioRf_wen and waddr != 0. Writes to x0 are ignored; x0 always reads 0.
- Write-through forwarding: in READ, when ioRf_wen and waddr == rs and rs != 0, the operand takes ioRf_wdata.
- Register writes are accepted in every state.
- Immediate formats:
  - I: ADDI group, loads, JALR, SYS.
  - S: stores.
  - B: branches.
  - U: LUI, AUIPC.
  - J: JAL.
  - All formats sign-extend from the instruction sign bit inst[31].
- fuType mapping:
  - ALU: OP, OP-IMM, OP-32, OP-IMM-32, LUI, AUIPC.
  - BRU: JAL, JALR, BRANCH.
  - LSU: LOAD, STORE.
  - SYS: ECALL, EBREAK.
- Illegal handling: any other opcode, or inst[1:0] != 2'b11, gives fuType 7 and illegal = 1; rdWen = 0 and the packet is still delivered.
- rdWen = 0 for STORE, BRANCH, SYS and illegal encodings.

## Timing
- Reset values: ioIFU_ready = 1; ioEXU_valid = 0; all other outputs 0; state = IDLE.
- Latency: handshake accepted in cycle N gives ioEXU_valid high in cycle N+2. Minimum issue interval is 3 cycles.
- Decode uses only latched values; input changes after acceptance have no effect.
- Backpressure: ioEXU_ready low holds HOLD indefinitely with outputs unchanged and ioIFU_ready = 0.
- ioIFU_valid is ignored outside IDLE.
- Reset asserted in any state returns the block to reset values on the next edge and discards the in-flight packet.

## Configuration
- IDU_RVM_EN defined: OP/OP-32 with funct7 = 0000001 decode to fuType MDU, with fuOp = {1'b0, funct3, word}.
- IDU_RVM_EN undefined: the same encodings decode as illegal (fuType 7, illegal = 1, rdWen = 0).

## Test plan
- addi x1,x0,5 (0x00500093) accepted at cycle N -> cycle N+2: valid=1, fuType 0, imm 5, src1 0, rd 1, rdWen 1.
- ioRf_wen x2=0x1234 during READ of add x3,x2,x2 (0x002101b3) -> src1 = src2 = 0x1234. A subsequent read of x2 returns 0x1234.
- Write 0xDEAD to x0, then add x4,x0,x0 -> src1 = src2 = 0; rdWen 1. sd x1,0(x0) -> rdWen 0.
- ioEXU_ready held 0 for 5 cycles in HOLD -> outputs stable, ioIFU_ready 0, extra ioIFU_valid pulses ignored. Ready high -> IDLE next cycle.
- Instruction 0xFFFFFFFF -> illegal 1, fuType 7. beq x0,x0,-4 (0xFE000EE3) -> fuType 1, imm 0xFFFF_FFFF_FFFF_FFFC.
- mul x5,x6,x7 (0x027302b3) -> fuType 3 with IDU_RVM_EN, illegal without. Reset asserted in READ -> valid 0, ready 1 the next cycle.
